// File: rtl/present_sbox_player_serial.sv
// present_sbox_player_serial: serialised PRESENT round (addRoundKey, sBoxLayer, pLayer) with valid/ready handshake
module Present_S_Box (
    input  logic [3:0] i_x,
    output logic [3:0] o_y
);
    localparam logic [63:0] LUT = 64'h21748FE3DA09B65C;
    assign o_y = LUT[{i_x, 2'b00} +: 4];
endmodule

module present_sbox_player_serial #(
    parameter int NUM_SBOX = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [63:0] state_in,
    input  logic [63:0] round_key,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] state_out,
    output logic        busy
);
    typedef enum logic [1:0] {IDLE, SUB, DONE} state_t;
    localparam logic [4:0] LAST = 5'(16 - NUM_SBOX);
    state_t      r_state, w_next;
    logic [63:0] r_st, r_state_out, w_sub, w_perm;
    logic [4:0]  r_cnt;
    logic [3:0]  w_sbox_in  [NUM_SBOX];
    logic [3:0]  w_sbox_out [NUM_SBOX];
    logic        w_last;
    if (!(NUM_SBOX == 1 || NUM_SBOX == 2 || NUM_SBOX == 4 || NUM_SBOX == 8 || NUM_SBOX == 16)) begin : g_bad
        $error("NUM_SBOX must be 1, 2, 4, 8 or 16");
    end
    for (genvar i = 0; i < NUM_SBOX; i++) begin : g_sbox
        assign w_sbox_in[i] = r_st[{r_cnt[3:0] + 4'(i), 2'b00} +: 4];
        Present_S_Box u_sbox (.i_x(w_sbox_in[i]), .o_y(w_sbox_out[i]));
    end
    // splice the current group of substituted nibbles into the state
    always_comb begin
        w_sub = r_st;
        for (int g = 0; g < NUM_SBOX; g++)
            w_sub[{r_cnt[3:0] + 4'(g), 2'b00} +: 4] = w_sbox_out[g];
    end
    for (genvar j = 0; j < 63; j++) begin : g_perm
        assign w_perm[(16 * j) % 63] = w_sub[j];
    end
    assign w_perm[63] = w_sub[63];
    assign w_last     = r_cnt == LAST;
    assign in_ready   = rst_n && r_state == IDLE;
    assign out_valid  = r_state == DONE;
    assign busy       = r_state != IDLE;
    assign state_out  = r_state_out;
    // FSM state register
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    // next-state decode
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = in_valid ? SUB : IDLE;
            SUB:     w_next = w_last ? DONE : SUB;
            DONE:    w_next = out_ready ? IDLE : DONE;
            default: w_next = IDLE;
        endcase
    end
    // working state, nibble counter and the registered round result
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            r_st        <= '0;
            r_cnt       <= '0;
            r_state_out <= '0;
        end else if (r_state == IDLE && in_valid) begin
            r_st  <= state_in ^ round_key;
            r_cnt <= '0;
        end else if (r_state == SUB) begin
            r_st  <= w_sub;
            r_cnt <= r_cnt + 5'(NUM_SBOX);
            if (w_last) r_state_out <= w_perm;
        end
endmodule
